// File: rtl/ksa_pkg.sv
// Shared constants and types for the pipelined Kogge-Stone adder/subtractor.
package ksa_pkg;
  localparam int KSA_WIDTH   = 32;
  localparam int KSA_LOG2W   = 5;
  localparam int KSA_LATENCY = 3;

  localparam int KSA_DIST1  = 1;
  localparam int KSA_DIST2  = 2;
  localparam int KSA_DIST4  = 4;
  localparam int KSA_DIST8  = 8;
  localparam int KSA_DIST16 = 16;

  typedef struct packed {
    logic [KSA_WIDTH-1:0] g;
    logic [KSA_WIDTH-1:0] p;
  } gp_t;
endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: combines each bit with the bit DIST positions below it.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [KSA_WIDTH-1:0] g_in,
  input  logic [KSA_WIDTH-1:0] p_in,
  output logic [KSA_WIDTH-1:0] g_out,
  output logic [KSA_WIDTH-1:0] p_out
);

  for (genvar i = 0; i < KSA_WIDTH; i++) begin : g_cell
    if (i >= DIST) begin : g_combine
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      assign p_out[i] = p_in[i] & p_in[i-DIST];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ksa_addsub_pipe.sv
// 32-bit three-stage Kogge-Stone adder/subtractor with valid/ready on both sides.
// Prefix distances 1,2 feed S1; distances 4,8,16 feed S2; S3 forms sum and flags.
module ksa_addsub_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH = KSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  logic [KSA_WIDTH-1:0] b_mod, g_raw, p_raw;
  logic                 c0;
  gp_t                  gp0, gp1, gp2, gp4, gp8;
  logic [KSA_WIDTH-1:0] g16, p16_unused;

  logic adv1, adv2, adv3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

  gp_t                  s1_gp_q, s1_gp_d;
  logic [KSA_WIDTH-1:0] s1_praw_q, s1_praw_d;
  logic                 s1_c0_q, s1_c0_d, s1_a31_q, s1_a31_d, s1_b31_q, s1_b31_d;

  logic [KSA_WIDTH-1:0] s2_g_q, s2_g_d, s2_praw_q, s2_praw_d;
  logic                 s2_c0_q, s2_c0_d, s2_a31_q, s2_a31_d, s2_b31_q, s2_b31_d;

  logic [KSA_WIDTH-1:0] sum_q, sum_d, sum_c;
  logic                 cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  // Carry-in folded into bit 0 generate so G[i:0] already includes it.
  assign b_mod = in_sub ? ~in_b : in_b;
  assign c0    = in_sub | in_cin;
  assign g_raw = in_a & b_mod;
  assign p_raw = in_a ^ b_mod;
  assign gp0   = '{g: {g_raw[KSA_WIDTH-1:1], g_raw[0] | (p_raw[0] & c0)}, p: p_raw};

  ksa_prefix_level #(.DIST(KSA_DIST1)) u_lvl1 (
    .g_in(gp0.g), .p_in(gp0.p), .g_out(gp1.g), .p_out(gp1.p));
  ksa_prefix_level #(.DIST(KSA_DIST2)) u_lvl2 (
    .g_in(gp1.g), .p_in(gp1.p), .g_out(gp2.g), .p_out(gp2.p));
  ksa_prefix_level #(.DIST(KSA_DIST4)) u_lvl4 (
    .g_in(s1_gp_q.g), .p_in(s1_gp_q.p), .g_out(gp4.g), .p_out(gp4.p));
  ksa_prefix_level #(.DIST(KSA_DIST8)) u_lvl8 (
    .g_in(gp4.g), .p_in(gp4.p), .g_out(gp8.g), .p_out(gp8.p));
  ksa_prefix_level #(.DIST(KSA_DIST16)) u_lvl16 (
    .g_in(gp8.g), .p_in(gp8.p), .g_out(g16), .p_out(p16_unused));

  // Each stage may advance whenever the one below it is empty or moving.
  assign adv3     = ~v3_q | out_ready;
  assign adv2     = ~v2_q | adv3;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  assign sum_c = s2_praw_q ^ {s2_g_q[KSA_WIDTH-2:0], s2_c0_q};

  always_comb begin
    v1_d      = adv1 ? in_valid : v1_q;
    v2_d      = adv2 ? v1_q : v2_q;
    v3_d      = adv3 ? v2_q : v3_q;

    s1_gp_d   = s1_gp_q;
    s1_praw_d = s1_praw_q;
    s1_c0_d   = s1_c0_q;
    s1_a31_d  = s1_a31_q;
    s1_b31_d  = s1_b31_q;
    if (adv1 && in_valid) begin
      s1_gp_d   = gp2;
      s1_praw_d = p_raw;
      s1_c0_d   = c0;
      s1_a31_d  = in_a[KSA_WIDTH-1];
      s1_b31_d  = b_mod[KSA_WIDTH-1];
    end

    s2_g_d    = s2_g_q;
    s2_praw_d = s2_praw_q;
    s2_c0_d   = s2_c0_q;
    s2_a31_d  = s2_a31_q;
    s2_b31_d  = s2_b31_q;
    if (adv2 && v1_q) begin
      s2_g_d    = g16;
      s2_praw_d = s1_praw_q;
      s2_c0_d   = s1_c0_q;
      s2_a31_d  = s1_a31_q;
      s2_b31_d  = s1_b31_q;
    end

    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv3 && v2_q) begin
      sum_d  = sum_c;
      cout_d = s2_g_q[KSA_WIDTH-1];
      ovf_d  = (s2_a31_q ~^ s2_b31_q) & (sum_c[KSA_WIDTH-1] ^ s2_a31_q);
      zero_d = ~|sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_gp_q   <= '0;
      s1_praw_q <= '0;
      s1_c0_q   <= 1'b0;
      s1_a31_q  <= 1'b0;
      s1_b31_q  <= 1'b0;
      s2_g_q    <= '0;
      s2_praw_q <= '0;
      s2_c0_q   <= 1'b0;
      s2_a31_q  <= 1'b0;
      s2_b31_q  <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_gp_q   <= s1_gp_d;
      s1_praw_q <= s1_praw_d;
      s1_c0_q   <= s1_c0_d;
      s1_a31_q  <= s1_a31_d;
      s1_b31_q  <= s1_b31_d;
      s2_g_q    <= s2_g_d;
      s2_praw_q <= s2_praw_d;
      s2_c0_q   <= s2_c0_d;
      s2_a31_q  <= s2_a31_d;
      s2_b31_q  <= s2_b31_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign out_valid = v3_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_ksa_addsub_pipe.sv
// Self-checking bench for ksa_addsub_pipe: directed table, handshake corner cases, random scoreboard.
module tb_ksa_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, in_cin;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [31:0] out_sum;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];

  ksa_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference: signed and unsigned integer arithmetic on 64-bit values.
  function automatic exp_t refModel(input logic [31:0] a, b, input logic sub, cin);
    exp_t e;
    longint sa, sb_v, res;
    longint unsigned ua, ub, ures;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    if (sub) begin
      res    = sa - sb_v;
      e.cout = (ua >= ub);
    end else begin
      res    = sa + sb_v + longint'(cin);
      ures   = ua + ub + longint'(cin);
      e.cout = (ures >= 64'h1_0000_0000);
    end
    e.sum  = res[31:0];
    e.ovf  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    e.zero = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, settle, book-keep handshakes, advance to next negedge.
  task automatic applyStimulus(input logic iv, input logic [31:0] a, b, input logic sub, cin,
                               input logic ordy, output logic acc, output logic rdy);
    exp_t e;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_sub    = sub;
    in_cin    = cin;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    acc = iv && in_ready;
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_sum", out_sum, e.sum);
        checkOutput("sb_cout", 32'(out_cout), 32'(e.cout));
        checkOutput("sb_ovf", 32'(out_ovf), 32'(e.ovf));
        checkOutput("sb_zero", 32'(out_zero), 32'(e.zero));
      end
    end
    if (acc) sb.push_back(refModel(a, b, sub, cin));
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    logic acc, rdy;
    for (int i = 0; i < max_cycles && sb.size() != 0; i++)
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy);
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t        vecs[8];
  logic [31:0] ops_a[5], ops_b[5];
  logic        acc, rdy;
  int          lat, accepted, k;
  logic [31:0] held_sum;

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, '{32'h00000001, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1}};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_sum", out_sum, 32'd0);
    checkOutput("rst_flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: latency and exact result per vector, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b;
      in_sub = vecs[i].sub; in_cin = vecs[i].cin; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d_sum", i), out_sum, vecs[i].exp.sum);
      checkOutput($sformatf("vec%0d_cout", i), 32'(out_cout), 32'(vecs[i].exp.cout));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].exp.ovf));
      checkOutput($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp.zero));
      @(negedge clk);
    end

    // Backpressure: five ops against a stalled consumer, only three fit.
    for (int i = 0; i < 5; i++) begin
      ops_a[i] = $urandom;
      ops_b[i] = $urandom;
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, ops_a[k], ops_b[k], k[0], 1'b1, 1'b0, acc, rdy);
      if (acc) k++;
    end
    checkOutput("bp_accepts", 32'(k), 32'd3);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    held_sum = out_sum;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, rdy);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, rdy);
    checkOutput("bp_sum_stable", out_sum, held_sum);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_stream_valid%0d", c), 32'(out_valid), 32'd1);
      if (k < 5) applyStimulus(1'b1, ops_a[k], ops_b[k], k[0], 1'b1, 1'b1, acc, rdy);
      else       applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy);
      if (acc) k++;
    end
    checkOutput("bp_all_accepted", 32'(k), 32'd5);
    drain(10);

    // Bubble collapse: second op enters while the first is stalled at the output.
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus((c == 0 || c == 2), $urandom, $urandom, 1'b0, 1'b0, 1'b0, acc, rdy);
      checkOutput($sformatf("bubble_in_ready%0d", c), 32'(rdy), 32'd1);
      if (acc) accepted++;
    end
    checkOutput("bubble_accepts", 32'(accepted), 32'd2);
    checkOutput("bubble_out_valid", 32'(out_valid), 32'd1);
    drain(10);

    // Reset mid-flight: two ops in the pipe, reset asserted between edges.
    applyStimulus(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b0, acc, rdy);
    applyStimulus(1'b1, 32'd30, 32'd40, 1'b0, 1'b0, 1'b0, acc, rdy);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, rdy);
    checkOutput("midrst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_sum", out_sum, 32'd0);
    checkOutput("midrst_flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, rdy);
      checkOutput("postrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic against the reference model.
    accepted = 0;
    for (int c = 0; c < 40000 && accepted < 10000; c++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFFFFFF;
        1: rb = 32'h80000000;
        2: rb = ra;
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, acc, rdy);
      if (acc) accepted++;
    end
    checkOutput("rand_accepted", 32'(accepted), 32'd10000);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_addsub_pipe.md
Name: ksa_addsub_pipe

Overview:
- 32-bit pipelined Kogge-Stone adder/subtractor with valid/ready handshake on both sides.
- Completes the arithmetic datapath around the combinational prefix stages: the adder direction plus the subtract direction, with registered output flags.
- Sits between the operand source (issue logic) and the result consumer (writeback). Provides backpressure and bubble collapsing.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (prefix depth fixed at 5 stages).
- LATENCY, 3, cycles from input handshake to output valid with no stall; fixed, informational only.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_sub  in  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1)
- in_cin  in  1  carry-in for add; ignored when in_sub=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  32  result
- out_cout  out  1  carry out of bit 31 (for sub: 1 = no borrow)
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0

Behaviour:
- Reset: all valid bits 0; out_sum=0, out_cout=0, out_ovf=0, out_zero=0; in_ready=1 combinationally after reset because all stages are empty.
- Reset asserted mid-operation: in-flight results are discarded; no output handshake completes while rst_n=0.
- Pre-process (comb, before S1):
  - b' = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin
  - g_i = a_i & b'_i, p_i = a_i ^ b'_i
  - carry-in is folded into bit 0: g0 = a0&b'0 | p0&c0. Keep the raw p vector for the sum.
- Stage S1 register: holds g, p after prefix distances 1 and 2, plus raw p, c0, a31, b'31.
- Stage S2 register: holds g after prefix distances 4, 8 and 16 (full group generates G[i:0]), plus raw p, c0, a31, b'31.
- Stage S3 register (output):
  - sum_0 = p_0 ^ c0, sum_i = p_i ^ G[i-1:0]
  - cout = G[31:0]
  - ovf = (a31 ~^ b'31) & (sum31 ^ a31)
  - zero = ~|sum
- Prefix cell at distance d, for i >= d: g_out[i] = g[i] | p[i]&g[i-d]; p_out[i] = p[i]&p[i-d]. For i < d, pass through.
- Handshake:
  - Transfer occurs on a cycle where valid & ready are both high.
  - adv3 = ~v3 | out_ready
  - adv2 = ~v2 | adv3
  - adv1 = ~v1 | adv2
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
- Each stage loads when its adv is high:
  - v1 <= in_valid
  - v2 <= v1
  - v3 <= v2
- Data registers load only when adv is high and the upstream valid is high. Data is held otherwise, including during bubbles.
- Latency: 3 cycles from the input handshake to out_valid with out_ready held high. Throughput: 1 result/cycle.
- Bubbles collapse: if v3=1 and out_ready=0 while S1 is empty, S1 and S2 still fill. in_ready drops only when all three stages are full and out_ready=0.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Simultaneous drain and fill in the same cycle is legal at every stage.

Decomposition:
- Shared package ksa_pkg holds:
  - KSA_WIDTH = 32
  - KSA_LOG2W = 5
  - prefix distance constants 1, 2, 4, 8, 16
  - struct/packed group for {g, p} vectors
- One sub-module: ksa_prefix_level, parameterized by DIST. It is a combinational generate loop of the gp cell over 32 bits.
- Five instances of ksa_prefix_level are placed around the S1 and S2 registers.

Test Plan:
- Add, no stall, out_ready=1: a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0. Expect out_valid exactly 3 cycles later with sum=0, cout=1, ovf=0, zero=1.
- Signed overflow: a=0x7FFFFFFF, b=1 (add) -> sum=0x80000000, ovf=1, cout=0. Then sub with a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Subtract borrow: a=5, b=7, sub=1, cin=1 (ignored). Expect sum=0xFFFFFFFE, cout=0, ovf=0, zero=0.
- Backpressure:
  - Stream 5 back-to-back ops with out_ready=0. in_ready must fall after exactly 3 accepts.
  - Then raise out_ready. Expect results in order, one per cycle, with no loss or duplication.
  - out_sum must stay stable while stalled.
- Bubble collapse: one op accepted, out_ready=0 for 4 cycles, second op arrives in cycle 2. Expect both to fill, in_ready high throughout, and order preserved.
- Reset mid-flight: 2 ops in flight, assert rst_n=0 asynchronously between edges. Expect out_valid=0 and all flags 0 immediately. After release, in_ready=1 and no stale result appears.
- Random compare: 10k random ops with random in_valid/out_ready. Compare against a reference model (a ± b with cin) for sum, cout and ovf.
